// File: rtl/car_status_display.sv
`default_nettype none
// ============================================================================
// Module      : car_status_display
// Description : Seven-segment scan display, turn-indicator blinker and BCD
//               odometer driven by the manual-driving controller status.
//               Optional macro CAR_DISP_HEARTBEAT_EN adds a dp heartbeat on
//               digit 0.
// Revision    : 1.0 - initial release
// ============================================================================
module car_status_display #(
    parameter int         SCAN_DIV    = 100000,
    parameter int         BLINK_DIV   = 50000000,
    parameter int         ODO_TICK    = 100000000,
    parameter logic [3:0] MOVING_CODE = 4'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        power_now,
    input  logic [3:0]  state,
    input  logic [3:0]  answer,
    input  logic        turn_left_signal,
    input  logic        turn_right_signal,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out,
    output logic        led_left,
    output logic        led_right,
    output logic [15:0] mileage
);

    localparam int c_SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int c_BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int c_ODO_W   = (ODO_TICK  > 1) ? $clog2(ODO_TICK)  : 1;

    localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST  = c_SCAN_W'(SCAN_DIV - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);
    localparam logic [c_ODO_W-1:0]   c_ODO_LAST   = c_ODO_W'(ODO_TICK - 1);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Ripple BCD increment; 9999 rolls over to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [c_SCAN_W-1:0]  r_scan_cnt;
    logic [2:0]           r_idx;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_phase;
    logic [c_ODO_W-1:0]   r_tick;
    logic [15:0]          r_mileage;
    logic [7:0]           r_seg_en;
    logic [7:0]           r_seg_out;
    logic                 r_led_left;
    logic                 r_led_right;

    logic [3:0]           w_nibble;
    logic                 w_blank;
    logic                 w_dp;
    logic                 w_turn_any;
    logic                 w_moving;

    assign w_turn_any = turn_left_signal | turn_right_signal;
    assign w_moving   = power_now && (state == MOVING_CODE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= 3'd0;
        end else if (r_scan_cnt == c_SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + c_SCAN_W'(1);
        end
    end

    always_comb begin
        w_nibble = 4'h0;
        w_blank  = 1'b0;
        case (r_idx)
            3'd7:       w_nibble = state;
            3'd6:       w_nibble = answer;
            3'd5, 3'd4: w_blank  = 1'b1;
            default:    w_nibble = r_mileage[{r_idx[1:0], 2'b00} +: 4];
        endcase
    end

`ifdef CAR_DISP_HEARTBEAT_EN
    logic [c_BLINK_W-1:0] r_hb_cnt;
    logic                 r_hb_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hb_cnt   <= '0;
            r_hb_phase <= 1'b0;
        end else if (r_hb_cnt == c_BLINK_LAST) begin
            r_hb_cnt   <= '0;
            r_hb_phase <= ~r_hb_phase;
        end else begin
            r_hb_cnt   <= r_hb_cnt + c_BLINK_W'(1);
        end
    end

    assign w_dp = r_hb_phase && (r_idx == 3'd0);
`else
    assign w_dp = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_en  <= 8'h00;
            r_seg_out <= 8'h00;
        end else if (!power_now || w_blank) begin
            r_seg_en  <= 8'h00;
            r_seg_out <= 8'h00;
        end else begin
            r_seg_en  <= 8'd1 << r_idx;
            r_seg_out <= {w_dp, hex_to_seg(w_nibble)};
        end
    end

    // Idle blinker parks with phase high so a new request starts with a full on-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (!w_turn_any) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (r_blink_cnt == c_BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led_left  <= 1'b0;
            r_led_right <= 1'b0;
        end else begin
            r_led_left  <= power_now & turn_left_signal  & r_phase;
            r_led_right <= power_now & turn_right_signal & r_phase;
        end
    end

    // Tick counter is never cleared outside reset, so partial moving time carries over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick    <= '0;
            r_mileage <= 16'h0000;
        end else if (w_moving) begin
            if (r_tick == c_ODO_LAST) begin
                r_tick    <= '0;
                r_mileage <= bcd_inc(r_mileage);
            end else begin
                r_tick    <= r_tick + c_ODO_W'(1);
            end
        end
    end

    assign seg_en    = r_seg_en;
    assign seg_out   = r_seg_out;
    assign led_left  = r_led_left;
    assign led_right = r_led_right;
    assign mileage   = r_mileage;

endmodule
`default_nettype wire

// File: tb/tb_car_status_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_car_status_display
// Description : Randomised self-checking bench for car_status_display against
//               a cycle-count based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_car_status_display;

    localparam int c_SCAN_DIV  = 4;
    localparam int c_BLINK_DIV = 8;
    localparam int c_ODO_TICK  = 10;
    localparam int c_ODO_FAST  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        power_now = 1'b0;
    logic [3:0]  state = 4'd0;
    logic [3:0]  answer = 4'd0;
    logic        turn_left_signal = 1'b0;
    logic        turn_right_signal = 1'b0;
    logic [7:0]  seg_en, seg_out, seg_en_f, seg_out_f;
    logic        led_left, led_right, led_left_f, led_right_f;
    logic [15:0] mileage, mileage_f;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: edges since reset, consecutive blink-request edges, moving edges.
    int          m_edge, m_run, m_moves;
    logic [7:0]  e_en, e_seg;
    logic        e_ll, e_lr;
    logic [15:0] e_mil, e_mil2;
    logic [7:0]  hex_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                  8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    car_status_display #(
        .SCAN_DIV(c_SCAN_DIV), .BLINK_DIV(c_BLINK_DIV), .ODO_TICK(c_ODO_TICK), .MOVING_CODE(4'd3)
    ) dut (
        .clk(clk), .rst(rst), .power_now(power_now), .state(state), .answer(answer),
        .turn_left_signal(turn_left_signal), .turn_right_signal(turn_right_signal),
        .seg_en(seg_en), .seg_out(seg_out), .led_left(led_left), .led_right(led_right),
        .mileage(mileage)
    );

    car_status_display #(
        .SCAN_DIV(c_SCAN_DIV), .BLINK_DIV(c_BLINK_DIV), .ODO_TICK(c_ODO_FAST), .MOVING_CODE(4'd3)
    ) dut_fast (
        .clk(clk), .rst(rst), .power_now(power_now), .state(state), .answer(answer),
        .turn_left_signal(turn_left_signal), .turn_right_signal(turn_right_signal),
        .seg_en(seg_en_f), .seg_out(seg_out_f), .led_left(led_left_f), .led_right(led_right_f),
        .mileage(mileage_f)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    task automatic model_reset();
        m_edge  = 0;
        m_run   = 0;
        m_moves = 0;
    endtask

    task automatic model_edge();
        int          idx;
        logic [3:0]  nib;
        logic [15:0] mil_now;
        logic        ph;
        idx     = (m_edge / c_SCAN_DIV) % 8;
        mil_now = to_bcd((m_moves / c_ODO_TICK) % 10000);
        if (idx == 7)      nib = state;
        else if (idx == 6) nib = answer;
        else if (idx < 4)  nib = mil_now[idx*4 +: 4];
        else               nib = 4'h0;
        if (power_now && idx != 4 && idx != 5) begin
            e_en  = 8'(1 << idx);
            e_seg = hex_tbl[nib];
`ifdef CAR_DISP_HEARTBEAT_EN
            if (idx == 0 && ((m_edge / c_BLINK_DIV) % 2) == 1) e_seg[7] = 1'b1;
`endif
        end else begin
            e_en  = 8'h00;
            e_seg = 8'h00;
        end
        ph    = ((m_run / c_BLINK_DIV) % 2) == 0;
        e_ll  = power_now & turn_left_signal & ph;
        e_lr  = power_now & turn_right_signal & ph;
        m_run = (turn_left_signal | turn_right_signal) ? m_run + 1 : 0;
        if (power_now && state == 4'd3) m_moves++;
        e_mil  = to_bcd((m_moves / c_ODO_TICK) % 10000);
        e_mil2 = to_bcd((m_moves / c_ODO_FAST) % 10000);
        m_edge++;
    endtask

    task automatic check_all();
        chk("seg_en", seg_en, e_en);
        chk("seg_out", seg_out, e_seg);
        chk("led_left", led_left, e_ll);
        chk("led_right", led_right, e_lr);
        chk("mileage", mileage, e_mil);
        chk("mileage_fast", mileage_f, e_mil2);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_seg_en"}, seg_en, 8'h00);
        chk({tag, "_seg_out"}, seg_out, 8'h00);
        chk({tag, "_leds"}, {led_left, led_right}, 2'b00);
        chk({tag, "_mileage"}, mileage, 16'h0000);
        chk({tag, "_mileage_fast"}, mileage_f, 16'h0000);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin : main
        logic        seen7, seen6, got_on;
        logic [15:0] held;

        #1;
        check_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Power off after reset: everything stays dark.
        repeat (100) cycle();
        check_zero("post_reset");

        power_now = 1'b1;
        state     = 4'd2;
        answer    = 4'hA;
        seen7     = 1'b0;
        seen6     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (seg_en == 8'h80) begin seen7 = 1'b1; chk("digit7_two", seg_out, 8'h5B); end
            if (seg_en == 8'h40) begin seen6 = 1'b1; chk("digit6_A", seg_out, 8'h77); end
        end
        chk("scan_reached_7_6", {seen7, seen6}, 2'b11);

        turn_left_signal = 1'b1;
        cycle();
        chk("led_left_first", led_left, 1'b1);
        repeat (40) cycle();
        turn_right_signal = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            chk("hazard_in_phase", led_right, led_left);
        end
        turn_left_signal  = 1'b0;
        turn_right_signal = 1'b0;

        state = 4'd3;
        repeat (25) cycle();
        chk("odo_25", mileage, 16'h0002);
        state = 4'd1;
        repeat (20) cycle();
        chk("odo_hold", mileage, 16'h0002);
        state = 4'd3;
        repeat (5) cycle();
        chk("odo_resume", mileage, 16'h0003);

        // Drop power while the left LED is lit.
        state            = 4'd3;
        turn_left_signal = 1'b1;
        got_on           = 1'b0;
        for (int i = 0; i < 20 && !got_on; i++) begin
            cycle();
            got_on = e_ll;
        end
        chk("blink_on_seen", got_on, 1'b1);
        held      = e_mil;
        power_now = 1'b0;
        cycle();
        chk("pwr_drop_led", led_left, 1'b0);
        chk("pwr_drop_seg_en", seg_en, 8'h00);
        chk("pwr_drop_mileage", mileage, held);
        repeat (15) cycle();
        chk("pwr_off_hold", mileage, held);
        power_now = 1'b1;
        repeat (20) cycle();
        turn_left_signal = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            power_now = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 3) == 0)
                state = ($urandom_range(0, 1) == 1) ? 4'd3 : 4'($urandom_range(0, 15));
            answer = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) turn_left_signal  = ~turn_left_signal;
            if ($urandom_range(0, 19) == 0) turn_right_signal = ~turn_right_signal;
            cycle();
        end

        // Asynchronous reset in the middle of activity.
        power_now = 1'b1;
        state     = 4'd3;
        turn_left_signal  = 1'b1;
        turn_right_signal = 1'b0;
        repeat (7) cycle();
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        turn_left_signal = 1'b0;
        repeat (40) cycle();

        model_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        state  = 4'd3;
        answer = 4'h5;
        while (m_moves < 20010) begin
            cycle();
            if (m_moves == 198)   chk("carry_0099", mileage_f, 16'h0099);
            if (m_moves == 200)   chk("carry_0100", mileage_f, 16'h0100);
            if (m_moves == 19998) chk("top_9999", mileage_f, 16'h9999);
            if (m_moves == 20000) chk("wrap_0000", mileage_f, 16'h0000);
        end
        chk("odo_long", mileage, 16'h2001);

        for (int i = 0; i < 200; i++) begin
            power_now = ($urandom_range(0, 7) != 0);
            state     = 4'($urandom_range(0, 15));
            answer    = 4'($urandom_range(0, 15));
            turn_right_signal = ($urandom_range(0, 1) == 1);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/car_status_display.md
Name: car_status_display

Overview:
- Output-side consumer for the manual-driving controller.
- Takes the controller's power flag, 4-bit state and 4-bit answer code, plus the driver turn-signal switches.
- Drives an 8-digit multiplexed seven-segment display, left and right turn-indicator LEDs, and an odometer that accumulates while the car is moving.
- Sits between the driving-mode controller and the board I/O pins.

Parameters:
SCAN_DIV, 100000, clk cycles per digit slot (1 kHz per-digit scan at 100 MHz)
BLINK_DIV, 50000000, clk cycles per turn-LED half period (1 Hz blink)
ODO_TICK, 100000000, clk cycles of MOVING per odometer increment
MOVING_CODE, 4'd3, state value that means "car moving"

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  asynchronous, active-high reset
power_now  input  1  controller power status, 1 = on
state  input  4  controller state code
answer  input  4  controller answer/event code
turn_left_signal  input  1  left turn switch
turn_right_signal  input  1  right turn switch
seg_en  output  8  digit enables, one-hot, active-high, bit n = digit n
seg_out  output  8  segments: bit0..6 = a..g, bit7 = dp, active-high
led_left  output  1  left indicator
led_right  output  1  right indicator
mileage  output  16  odometer, 4 BCD digits, [15:12] = thousands

Behaviour:
Clock and reset:
- Single clock `clk`. `rst` is asynchronous and active-high.
- All state is in flops cleared by `rst`.
- Reset values: seg_en = 0, seg_out = 0, led_left = 0, led_right = 0, mileage = 16'h0000. All internal counters = 0; scan index = 0; blink phase = 1.

Scan:
- A divider counts 0..SCAN_DIV-1.
- At terminal count the 3-bit digit index increments, wrapping 7 -> 0.

Digit map:
- Digit 7 shows hex of `state`.
- Digit 6 shows hex of `answer`.
- Digits 5 and 4 are blank (seg_en bit 0 for that slot).
- Digits 3..0 show mileage BCD.
- Hex decode is standard 0-F, active-high.

Display timing:
- seg_en and seg_out are registered; they update on the cycle after the index changes.
- Latency from an input change to the displayed segments is at most 1 cycle once that digit is selected.

Power off:
- When power_now = 0: seg_en = 0, seg_out = 0, led_left = led_right = 0.
- Scan and blink counters keep running.
- mileage holds its value; only rst clears it.

Blink:
- While neither turn signal is active, the blink counter is held at 0 with phase = 1.
- When either signal becomes active, the counter runs 0..BLINK_DIV-1 and phase toggles at terminal count.
- led_left = power_now & turn_left_signal & phase; led_right likewise.
- Both signals asserted gives hazard blinking: both LEDs in phase.
- An LED turns on the cycle after its signal rises, giving a full on-period first.

Odometer:
- The tick counter increments each cycle that power_now = 1 and state == MOVING_CODE.
- At ODO_TICK-1 the tick counter wraps to 0 and mileage increments in BCD with digit carries (e.g. 0099 -> 0100).
- 9999 wraps to 0000.
- Leaving MOVING holds the tick counter; it is not cleared, so partial time accumulates.

Reset mid-operation:
- Outputs clear asynchronously; the display restarts at digit 0 after release.

Optional Feature:
Macro CAR_DISP_HEARTBEAT_EN.
- When defined: while power_now = 1, the dp segment (seg_out[7]) of digit 0 follows a free-running phase that toggles every BLINK_DIV cycles, independent of the turn signals, as a liveness heartbeat.
- When undefined: dp is always 0 and no extra counter is synthesised.

Test Plan:
(All scenarios use SCAN_DIV=4, BLINK_DIV=8, ODO_TICK=10, MOVING_CODE=3.)
1. Reset: assert rst for 3 cycles, then release with power_now=0 -> all outputs 0 and mileage 0000; they stay 0 for 100 cycles.
2. Scan: power_now=1, state=2, answer=4'hA -> seg_en walks 01,02,04,08,00,00,40,80 every 4 cycles; digit 7 seg_out = 8'h5B ("2"); digit 6 = 8'h77 ("A"); digits 3..0 = 8'h3F ("0").
3. Left blink: turn_left_signal=1 -> led_left = 1 from the next cycle for 8 cycles, 0 for 8, repeating; led_right stays 0. Setting both signals gives both LEDs toggling identically.
4. Odometer: state=3 for 25 cycles -> mileage = 0002; switch to state=1 for 20 cycles (hold), then state=3 for 5 cycles -> mileage = 0003.
5. Wrap: preload by running until 9999, then 10 more moving cycles -> mileage = 0000; carry 0099 -> 0100 checked on the way.
6. Power drop mid-blink: power_now -> 0 while led_left = 1 -> led_left and seg_en = 0 on the next cycle; mileage unchanged. Restoring power resumes display with mileage preserved.
